// File: rtl/la_pkg.sv
// la_pkg: shared definitions for the logic-analyzer capture path.
//   la_state_e  capture sequencer states
//   TRIG_*      trigger mode encodings for trig_mode
//   LA_DEPTH    default number of entries per trace RAM
package la_pkg;

    localparam int LA_DEPTH = 80;

    localparam logic [1:0] TRIG_IMM  = 2'b00;
    localparam logic [1:0] TRIG_RISE = 2'b01;
    localparam logic [1:0] TRIG_FALL = 2'b10;
    localparam logic [1:0] TRIG_ANY  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        WAIT_TRIG,
        POST,
        DONE
    } la_state_e;

endpackage

// File: rtl/la_capture_ctrl_if.sv
// la_capture_ctrl_if: trace RAM write port.
//   wr_en    one-cycle write strobe (valid); there is no ready, the RAM must
//            accept every strobe. wr_addr/wr_data are meaningful while wr_en=1
//            and are held until the next strobe.
//   wr_addr  entry address, 0..DEPTH-1
//   wr_data  bits [2i+1:2i] = {older, newer} sample of channel i
// Modports: master = capture controller, slave = trace RAM.
interface la_capture_ctrl_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (output wr_en, output wr_addr, output wr_data);
    modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/la_sample_ticker.sv
// la_sample_ticker: programmable sample-rate divider.
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         restart the count from 0 (first tick div+1 cycles later)
//   en          count only while enabled
//   div         period minus 1, in clk cycles
//   tick        high for one cycle when the count reaches div
module la_sample_ticker #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);
    logic [DIV_W-1:0] cnt;

    assign tick = en && (cnt == div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/la_capture_ctrl.sv
// la_capture_ctrl: trigger and capture sequencer for the logic analyzer.
// Samples din at a programmable rate, packs sample pairs into one RAM entry,
// writes a circular buffer with pre-trigger history and freezes after a
// programmable number of post-trigger entries.
//   clk, rst_n    clock, asynchronous active-low reset
//   arm           pulse: latch div/trig_ch/trig_mode/post_cnt, (re)start capture
//   abort         pulse: back to IDLE, no done (wins over arm)
//   div           sample period minus 1
//   trig_ch       channel used for edge triggers
//   trig_mode     00 immediate, 01 rising, 10 falling, 11 either edge
//   post_cnt      entries written after the trigger entry (clamped to DEPTH-1)
//   din           asynchronous trace inputs
//   wr_bus        trace RAM write port (master)
//   busy          high in FILL/WAIT_TRIG/POST
//   triggered     high from trigger detection until next arm/abort
//   done          sticky completion flag
//   start_addr    oldest entry address, valid while done=1
//   dbg_state     current sequencer state
module la_capture_ctrl
    import la_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int DEPTH  = LA_DEPTH,
    parameter int ADDR_W = 7,
    parameter int DIV_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                arm,
    input  logic                abort,
    input  logic [DIV_W-1:0]    div,
    input  logic [1:0]          trig_ch,
    input  logic [1:0]          trig_mode,
    input  logic [ADDR_W-1:0]   post_cnt,
    input  logic [N_CH-1:0]     din,
    la_capture_ctrl_if.master   wr_bus,
    output logic                busy,
    output logic                triggered,
    output logic                done,
    output logic [ADDR_W-1:0]   start_addr,
    output la_state_e           dbg_state
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    la_state_e         state;
    logic [DIV_W-1:0]  div_l;
    logic [1:0]        trig_ch_l;
    logic [1:0]        trig_mode_l;
    logic [ADDR_W-1:0] post_l;
    logic [N_CH-1:0]   din_s1, din_s2;
    logic [N_CH-1:0]   prev_smp, older;
    logic              prev_valid;
    logic              phase;
    logic [ADDR_W-1:0] nxt_addr;
    // Entries still to write: pre-trigger count in FILL, post count in POST.
    logic [ADDR_W-1:0] cnt;

    logic              tick, run, trig_hit, cur_bit, prv_bit;
    logic [ADDR_W-1:0] post_c, pre_in;
    logic [2*N_CH-1:0] pair;

    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return (a == LAST) ? '0 : a + 1'b1;
    endfunction

    assign dbg_state = state;
    assign run    = (state == FILL) || (state == WAIT_TRIG) || (state == POST);
    assign post_c = (post_cnt > LAST) ? LAST : post_cnt;
    assign pre_in = LAST - post_c;

    la_sample_ticker #(.DIV_W(DIV_W)) u_ticker (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (arm | abort),
        .en    (run),
        .div   (div_l),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_s1 <= '0;
            din_s2 <= '0;
        end else begin
            din_s1 <= din;
            din_s2 <= din_s1;
        end
    end

    always_comb begin
        pair = '0;
        for (int i = 0; i < N_CH; i++) begin
            pair[2*i+1] = older[i];
            pair[2*i]   = din_s2[i];
        end
    end

    // Edge modes compare against the previous tick's sample, so they cannot
    // fire until one sample has been taken since arm.
    assign cur_bit = din_s2[trig_ch_l];
    assign prv_bit = prev_smp[trig_ch_l];
    always_comb begin
        trig_hit = 1'b0;
        case (trig_mode_l)
            TRIG_IMM:  trig_hit = 1'b1;
            TRIG_RISE: trig_hit = prev_valid && !prv_bit && cur_bit;
            TRIG_FALL: trig_hit = prev_valid && prv_bit && !cur_bit;
            TRIG_ANY:  trig_hit = prev_valid && (prv_bit ^ cur_bit);
            default:   trig_hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            div_l          <= '0;
            trig_ch_l      <= '0;
            trig_mode_l    <= '0;
            post_l         <= '0;
            prev_smp       <= '0;
            older          <= '0;
            prev_valid     <= 1'b0;
            phase          <= 1'b0;
            nxt_addr       <= '0;
            cnt            <= '0;
            busy           <= 1'b0;
            triggered      <= 1'b0;
            done           <= 1'b0;
            start_addr     <= '0;
            wr_bus.wr_en   <= 1'b0;
            wr_bus.wr_addr <= '0;
            wr_bus.wr_data <= '0;
        end else begin
            wr_bus.wr_en <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                busy      <= 1'b0;
                triggered <= 1'b0;
                done      <= 1'b0;
            end else if (arm) begin
                div_l          <= div;
                trig_ch_l      <= trig_ch;
                trig_mode_l    <= trig_mode;
                post_l         <= post_c;
                cnt            <= pre_in;
                state          <= (pre_in == '0) ? WAIT_TRIG : FILL;
                busy           <= 1'b1;
                triggered      <= 1'b0;
                done           <= 1'b0;
                phase          <= 1'b0;
                prev_valid     <= 1'b0;
                nxt_addr       <= '0;
                wr_bus.wr_addr <= '0;
            end else if (tick) begin
                prev_smp   <= din_s2;
                prev_valid <= 1'b1;
                phase      <= ~phase;
                if (!phase) begin
                    older <= din_s2;
                end else begin
                    wr_bus.wr_en   <= 1'b1;
                    wr_bus.wr_addr <= nxt_addr;
                    wr_bus.wr_data <= pair;
                    nxt_addr       <= addr_inc(nxt_addr);
                end
                case (state)
                    FILL: begin
                        if (phase) begin
                            if (cnt == 1) state <= WAIT_TRIG;
                            cnt <= cnt - 1'b1;
                        end
                    end
                    WAIT_TRIG: begin
                        if (trig_hit) begin
                            triggered <= 1'b1;
                            if (!phase) begin
                                // Trigger entry is still open: count it with the post entries.
                                state <= POST;
                                cnt   <= post_l + 1'b1;
                            end else if (post_l == '0) begin
                                state      <= DONE;
                                busy       <= 1'b0;
                                done       <= 1'b1;
                                start_addr <= addr_inc(nxt_addr);
                            end else begin
                                state <= POST;
                                cnt   <= post_l;
                            end
                        end
                    end
                    POST: begin
                        if (phase) begin
                            if (cnt == 1) begin
                                state      <= DONE;
                                busy       <= 1'b0;
                                done       <= 1'b1;
                                start_addr <= addr_inc(nxt_addr);
                            end
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
